wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, legal 1..15: wait cycles after which a pending source is promoted to top priority.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 <s>_valid  in  1  source <s> holds a write-back request; <s> in {alu, mem, imm}, plus {acc1, acc2} under ACC_WB_EN.
REQ-005 <s>_rd  in  5  destination register index for source <s>.
REQ-006 <s>_data  in  32  write-back value for source <s>.
REQ-007 <s>_ready  out  1  combinational grant to source <s>; transfer occurs when <s>_valid and <s>_ready are both high.
REQ-008 rf_we  out  1  register-file write enable, registered.
REQ-009 rf_waddr  out  5  register-file write address, registered.
REQ-010 rf_wdata  out  32  register-file write data, registered.
REQ-011 wb_src_sel  out  3  winning source, registered: 000 alu, 001 mem, 010 imm, 011 acc1, 100 acc2.
REQ-012 wb_busy  out  1  combinational contention flag, high when two or more <s>_valid are high.

Function
REQ-013 At most one <s>_ready SHALL be high in any cycle; no ready when no valid.
REQ-014 A source SHALL hold valid, rd, data stable until accepted; the arbiter does not re-check this.
REQ-015 Normal priority: mem > alu > imm > accelerator pair.
REQ-016 Accelerator pair: round-robin pointer; with both acc valid, grant the one not last granted; pointer toggles only on an accelerator accept.
REQ-017 Per-source 4-bit wait counter: +1 when valid and not ready, saturate at STARVE_LIMIT, clear on accept or when valid low.
REQ-018 Any source with counter == STARVE_LIMIT SHALL win over REQ-015; among several starved, lowest wb_src_sel encoding wins.
REQ-019 Latency 1: accepted rd/data/encoding appear on rf_waddr/rf_wdata/wb_src_sel the next cycle with rf_we high.
REQ-020 Accepted rd == 0: transfer completes, rf_waddr/rf_wdata/wb_src_sel update, rf_we stays 0.
REQ-021 Cycle with no accept: rf_we 0 next cycle; rf_waddr, rf_wdata, wb_src_sel hold prior values.
REQ-022 Sustained throughput one accept per cycle, no bubbles while any valid is high.
REQ-023 Same-rd requests from two sources: serialized in grant order; later grant is the final register value.

Reset
REQ-024 While rst_n low at a clock edge: rf_we 0, rf_waddr 0, rf_wdata 0, wb_src_sel 000, all wait counters 0, round-robin pointer favours acc1.
REQ-025 While rst_n low, every <s>_ready SHALL be 0; a request pending when reset asserts is dropped, no partial write.
REQ-026 First grant possible in the first cycle with rst_n high.

Configuration
REQ-027 Macro ACC_WB_EN defined: acc1/acc2 ports present, arbitrated per REQ-016/REQ-018, encodings 011/100 reachable.
REQ-028 ACC_WB_EN undefined: acc ports, their counters and the pointer absent; wb_src_sel never 011/100; all other behaviour identical.

Verification
REQ-029 alu_valid=1 rd=5 data=0x1234_5678 alone -> alu_ready same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, wb_src_sel=000.
REQ-030 mem, alu, imm valid together, each rd nonzero -> grants mem, alu, imm on three consecutive cycles; wb_busy=1 in first two cycles; rf_we high three cycles.
REQ-031 mem valid continuously with new data each cycle, imm valid held, STARVE_LIMIT=4 -> imm waits exactly 4 cycles, granted in cycle 5, mem resumes after.
REQ-032 alu_valid=1 rd=0 data=0xFFFF_FFFF -> alu_ready=1; next cycle rf_we=0, rf_waddr=0, wb_src_sel=000.
REQ-033 ACC_WB_EN, acc1 and acc2 valid from reset with no others -> grants acc1, acc2, acc1, acc2 alternating; wb_src_sel 011,100,...
REQ-034 rst_n low for one cycle while mem_valid high and mem_ready would assert -> mem_ready=0 that cycle, rf_we=0 next cycle, counters cleared, mem granted after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter merging several result sources into one
// register-file write port.
//   Priority mem > alu > imm > accelerator pair (round-robin between acc1/acc2).
//   Any source waiting STARVE_LIMIT cycles is promoted above that order; among
//   promoted sources the lowest wb_src_sel encoding wins.
//   Optional feature macro: ACC_WB_EN adds the acc1/acc2 sources.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   <s>_valid/_rd/_data        request from source s (alu, mem, imm[, acc1, acc2])
//   <s>_ready                  combinational grant to source s
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
//   wb_src_sel                 registered winning source encoding
//   wb_busy                    combinational: two or more requests pending
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        imm_valid,
  input  logic [4:0]  imm_rd,
  input  logic [31:0] imm_data,
  output logic        imm_ready,
`ifdef ACC_WB_EN
  input  logic        acc1_valid,
  input  logic [4:0]  acc1_rd,
  input  logic [31:0] acc1_data,
  output logic        acc1_ready,
  input  logic        acc2_valid,
  input  logic [4:0]  acc2_rd,
  input  logic [31:0] acc2_data,
  output logic        acc2_ready,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [2:0]  wb_src_sel,
  output logic        wb_busy
);

`ifdef ACC_WB_EN
  localparam int unsigned NSRC = 5;
`else
  localparam int unsigned NSRC = 3;
`endif
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 4;

  // Source vectors indexed by wb_src_sel encoding
  logic [NSRC-1:0]   valid;
  logic [NSRC-1:0]   grant;
  logic [NSRC-1:0]   starved;
  logic [RD_W-1:0]   rd       [NSRC];
  logic [DATA_W-1:0] data     [NSRC];
  logic [CNT_W-1:0]  wait_cnt [NSRC];
  logic              grant_any;
  logic [SEL_W-1:0]  grant_sel;
  logic [RD_W-1:0]   win_rd;
  logic [DATA_W-1:0] win_data;

  assign valid[0] = alu_valid;
  assign valid[1] = mem_valid;
  assign valid[2] = imm_valid;
  assign rd[0]    = alu_rd;
  assign rd[1]    = mem_rd;
  assign rd[2]    = imm_rd;
  assign data[0]  = alu_data;
  assign data[1]  = mem_data;
  assign data[2]  = imm_data;

  assign alu_ready = grant[0];
  assign mem_ready = grant[1];
  assign imm_ready = grant[2];

`ifdef ACC_WB_EN
  logic acc2_last;  // last accelerator granted was acc2; reset favours acc1

  assign valid[3]   = acc1_valid;
  assign valid[4]   = acc2_valid;
  assign rd[3]      = acc1_rd;
  assign rd[4]      = acc2_rd;
  assign data[3]    = acc1_data;
  assign data[4]    = acc2_data;
  assign acc1_ready = grant[3];
  assign acc2_ready = grant[4];

  // Round-robin pointer moves only when an accelerator is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc2_last <= 1'b1;
    end else if (grant[3] || grant[4]) begin
      acc2_last <= grant[4];
    end
  end
`endif

  // Two or more bits set <=> clearing the lowest set bit leaves a nonzero value
  assign wb_busy = (valid & (valid - NSRC'(1))) != '0;

  always_comb begin
    for (int i = 0; i < int'(NSRC); i++) begin
      starved[i] = valid[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Winner selection: starved sources first (lowest encoding), then fixed order
  always_comb begin
    grant_any = 1'b0;
    grant_sel = '0;
    grant     = '0;
    win_rd    = '0;
    win_data  = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (!grant_any && starved[i]) begin
        grant_any = 1'b1;
        grant_sel = SEL_W'(i);
      end
    end
    if (!grant_any) begin
      grant_any = 1'b1;
      if (valid[1])      grant_sel = SEL_W'(1);
      else if (valid[0]) grant_sel = SEL_W'(0);
      else if (valid[2]) grant_sel = SEL_W'(2);
`ifdef ACC_WB_EN
      else if (valid[3] && valid[4]) grant_sel = acc2_last ? SEL_W'(3) : SEL_W'(4);
      else if (valid[3]) grant_sel = SEL_W'(3);
      else if (valid[4]) grant_sel = SEL_W'(4);
`endif
      else grant_any = 1'b0;
    end
    for (int i = 0; i < int'(NSRC); i++) begin
      if (grant_sel == SEL_W'(i)) begin
        grant[i] = grant_any && rst_n;
        win_rd   = rd[i];
        win_data = data[i];
      end
    end
  end

  // Wait counters: count blocked cycles, saturate at the starvation limit
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NSRC); i++) begin
      if (!rst_n || !valid[i] || grant[i]) begin
        wait_cnt[i] <= '0;
      end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
        wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Register-file write port; rd==0 updates the address/data but never writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      wb_src_sel <= '0;
    end else begin
      rf_we <= grant_any && (win_rd != '0);
      if (grant_any) begin
        rf_waddr   <= win_rd;
        rf_wdata   <= win_data;
        wb_src_sel <= grant_sel;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic for wb_arbiter,
// checked against a rule-level reference model (priority list, wait counts,
// round-robin memory). Define ACC_WB_EN to exercise the accelerator sources.
module tb_wb_arbiter;
`ifdef ACC_WB_EN
  localparam int NS = 5;
`else
  localparam int NS = 3;
`endif
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  v = '0;
  logic [4:0]  rdv [5];
  logic [31:0] dat [5];
  logic        alu_ready, mem_ready, imm_ready, acc1_ready, acc2_ready;
  logic        rf_we, wb_busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  wb_src_sel;
  logic [4:0]  rdy;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(v[0]), .alu_rd(rdv[0]), .alu_data(dat[0]), .alu_ready(alu_ready),
    .mem_valid(v[1]), .mem_rd(rdv[1]), .mem_data(dat[1]), .mem_ready(mem_ready),
    .imm_valid(v[2]), .imm_rd(rdv[2]), .imm_data(dat[2]), .imm_ready(imm_ready),
`ifdef ACC_WB_EN
    .acc1_valid(v[3]), .acc1_rd(rdv[3]), .acc1_data(dat[3]), .acc1_ready(acc1_ready),
    .acc2_valid(v[4]), .acc2_rd(rdv[4]), .acc2_data(dat[4]), .acc2_ready(acc2_ready),
`endif
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_src_sel(wb_src_sel), .wb_busy(wb_busy)
  );

`ifndef ACC_WB_EN
  assign acc1_ready = 1'b0;
  assign acc2_ready = 1'b0;
`endif

  always_comb begin
    rdy    = '0;
    rdy[0] = alu_ready;
    rdy[1] = mem_ready;
    rdy[2] = imm_ready;
    rdy[3] = acc1_ready;
    rdy[4] = acc2_ready;
  end

  // Reference model state
  int          w [5];
  int          acc_last;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [2:0]  exp_sel;
  int          obs_g;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) w[i] = 0;
    acc_last = 4;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_sel  = '0;
  endtask

  // Winner by the arbitration rules; -1 when nobody requests
  function automatic int pick();
    int prio [3] = '{1, 0, 2};
    for (int i = 0; i < NS; i++)
      if (v[i] && w[i] >= LIM) return i;
    foreach (prio[k])
      if (v[prio[k]]) return prio[k];
    if (NS == 5) begin
      if (v[3] && v[4]) return (acc_last == 4) ? 3 : 4;
      if (v[3]) return 3;
      if (v[4]) return 4;
    end
    return -1;
  endfunction

  task automatic req(input int s, input logic [4:0] r, input logic [31:0] d);
    v[s]   = 1'b1;
    rdv[s] = r;
    dat[s] = d;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic cycle();
    int g;
    logic [4:0] exp_rdy;
    @(negedge clk);
    g = rst_n ? pick() : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_g = -1;
    for (int i = 0; i < 5; i++) if (rdy[i]) obs_g = i;
    check("ready",    64'(rdy), 64'(exp_rdy));
    check("busy",     64'(wb_busy), 64'($countones(v) >= 2));
    check("rf_we",    64'(rf_we), 64'(exp_we));
    check("rf_waddr", 64'(rf_waddr), 64'(exp_addr));
    check("rf_wdata", 64'(rf_wdata), 64'(exp_data));
    check("src_sel",  64'(wb_src_sel), 64'(exp_sel));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_we = (g >= 0) && (rdv[g] != 5'd0);
      if (g >= 0) begin
        exp_addr = rdv[g];
        exp_data = dat[g];
        exp_sel  = 3'(g);
        if (g >= 3) acc_last = g;
      end
      for (int i = 0; i < NS; i++)
        w[i] = (!v[i] || i == g) ? 0 : ((w[i] < LIM) ? w[i] + 1 : LIM);
    end
    #1;
  endtask

  initial begin
    int n;
    int order [3] = '{1, 0, 2};
    for (int i = 0; i < 5; i++) begin
      rdv[i] = '0;
      dat[i] = '0;
    end
    model_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cycle();  // reset state, no grants while in reset
    rst_n = 1'b1;

`ifdef ACC_WB_EN
    // Accelerator pair alternates, acc1 first out of reset
    req(3, 5'd10, 32'hA1);
    req(4, 5'd11, 32'hA2);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("acc_rr", 64'(obs_g), 64'((k % 2 == 0) ? 3 : 4));
      if (obs_g >= 3) req(obs_g, rdv[obs_g], $urandom);
    end
    v = '0;
    cycle();
`endif

    // Lone alu request
    req(0, 5'd5, 32'h1234_5678);
    cycle();
    check("lone_grant", 64'(obs_g), 64'd0);
    v = '0;
    check("lone_we",   64'(rf_we), 64'd1);
    check("lone_addr", 64'(rf_waddr), 64'd5);
    check("lone_data", 64'(rf_wdata), 64'h1234_5678);
    check("lone_sel",  64'(wb_src_sel), 64'd0);

    // Write to r0 completes but does not write
    req(0, 5'd0, 32'hFFFF_FFFF);
    cycle();
    v = '0;
    check("r0_we",   64'(rf_we), 64'd0);
    check("r0_addr", 64'(rf_waddr), 64'd0);
    check("r0_sel",  64'(wb_src_sel), 64'd0);

    // Three-way contention resolves in priority order with no bubbles
    cycle();
    req(1, 5'd7, 32'h77);
    req(0, 5'd8, 32'h88);
    req(2, 5'd9, 32'h99);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("prio_order", 64'(obs_g), 64'(order[k]));
      check("prio_we",    64'(rf_we), 64'd1);
      if (obs_g >= 0) v[obs_g] = 1'b0;
    end
    v = '0;
    cycle();

    // imm starves behind a continuous mem stream, then mem resumes
    req(1, 5'd1, $urandom);
    req(2, 5'd2, 32'h2222);
    n = 0;
    do begin
      cycle();
      n++;
      if (obs_g == 1) req(1, 5'd1, $urandom);
    end while (obs_g != 2 && n < 20);
    check("starve_wait", 64'(n), 64'd5);
    v[2] = 1'b0;
    cycle();
    check("starve_resume", 64'(obs_g), 64'd1);
    v = '0;
    cycle();

    // Reset while mem is requesting drops the request
    req(1, 5'd3, 32'h3333);
    rst_n = 1'b0;
    cycle();
    check("rst_no_grant", 64'(obs_g), 64'hFFFF_FFFF_FFFF_FFFF);
    rst_n = 1'b1;
    cycle();
    check("rst_release_grant", 64'(obs_g), 64'd1);
    check("rst_release_we",    64'(rf_we), 64'd1);
    v = '0;

    // Randomized traffic with occasional reset pulses
    for (int c = 0; c < 800; c++) begin
      if (obs_g >= 0) begin
        if ($urandom_range(0, 1) == 1) req(obs_g, 5'($urandom_range(0, 31)), $urandom);
        else v[obs_g] = 1'b0;
      end
      for (int s = 0; s < NS; s++)
        if (!v[s] && $urandom_range(0, 2) == 0) req(s, 5'($urandom_range(0, 31)), $urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
